// File: rtl/seven_seg_reader.sv
// Reads a time-multiplexed 4-digit 7-segment bus back into a 16-bit word.
// Debounces each digit, decodes the segment pattern, and emits one valid pulse per complete frame.
module seven_seg_reader #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  dig_sel,
    output logic [15:0] value,
    output logic        valid,
    output logic        frame_err,
    output logic        timeout
);

    localparam int unsigned SEG_W  = 7;
    localparam int unsigned DIG_W  = 4;
    localparam int unsigned BUS_W  = SEG_W + DIG_W;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned STAB_W = 8;
    localparam int unsigned IDLE_W = 20;

    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_PRE  = IDLE_W'(TIMEOUT_CYCLES - 2);

    logic [BUS_W-1:0]              s1, s2, prev;
    logic [STAB_W-1:0]             stab, stab_n;
    logic                          armed, armed_n;
    logic [DIG_W-1:0][NIB_W-1:0]   slots, slots_n;
    logic [DIG_W-1:0]              mask, mask_n, errmask, errmask_n;
    logic [IDLE_W-1:0]             idle, idle_n;

    logic [DIG_W-1:0]  dig_c;
    logic [NIB_W-1:0]  nib_c;
    logic              bad_c, changed_c, onehot_c, capture_c, complete_c, expire_c, err_any_c;

    // Inverse of the team encoder; {error, nibble}. All-segments-on always reads as 8.
    function automatic logic [NIB_W:0] decode(input logic [SEG_W-1:0] pat);
        case (pat)
            7'b1111110: decode = 5'h00;
            7'b0110000: decode = 5'h01;
            7'b1101101: decode = 5'h02;
            7'b1111001: decode = 5'h03;
            7'b0110011: decode = 5'h04;
            7'b1011011: decode = 5'h05;
            7'b1011111: decode = 5'h06;
            7'b1110000: decode = 5'h07;
            7'b1111111: decode = 5'h08;
            7'b1110011: decode = 5'h09;
            7'b1110111: decode = 5'h0A;
            7'b0011111: decode = 5'h0B;
            7'b1111000: decode = 5'h0C;
            7'b1100111: decode = 5'h0D;
            7'b0000000: decode = 5'h0E;
            default:    decode = 5'h10;
        endcase
    endfunction

    // Stability tracking, capture, frame assembly and idle timeout.
    always_comb begin
        stab_n    = stab;
        armed_n   = armed;
        slots_n   = slots;
        mask_n    = mask;
        errmask_n = errmask;
        idle_n    = idle;

        dig_c              = s2[DIG_W-1:0];
        {bad_c, nib_c}     = decode(s2[BUS_W-1:DIG_W]);
        changed_c          = (s2 != prev);
        onehot_c           = (dig_c != '0) && ((dig_c & (dig_c - DIG_W'(1))) == '0);
        capture_c          = !changed_c && armed && (stab == STAB_LAST) && onehot_c;
        expire_c           = !capture_c && (mask != '0) && (idle == IDLE_PRE);

        if (changed_c) begin
            stab_n  = '0;
            armed_n = 1'b1;
        end else if (stab != '1) begin
            stab_n = stab + STAB_W'(1);
        end

        if (capture_c) begin
            armed_n = 1'b0;
            for (int k = 0; k < int'(DIG_W); k++) begin
                if (dig_c[k]) begin
                    slots_n[k]   = nib_c;
                    mask_n[k]    = 1'b1;
                    errmask_n[k] = bad_c;
                end
            end
        end

        complete_c = capture_c && (mask_n == '1);
        err_any_c  = |errmask_n;

        if (capture_c || expire_c) begin
            idle_n = '0;
        end else if (idle != IDLE_LAST) begin
            idle_n = idle + IDLE_W'(1);
        end

        if (complete_c || expire_c) begin
            mask_n    = '0;
            errmask_n = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1        <= '0;
            s2        <= '0;
            prev      <= '0;
            stab      <= '0;
            armed     <= 1'b0;
            slots     <= '0;
            mask      <= '0;
            errmask   <= '0;
            idle      <= '0;
            value     <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            s1        <= {seg_in, dig_sel};
            s2        <= s1;
            prev      <= s2;
            stab      <= stab_n;
            armed     <= armed_n;
            slots     <= slots_n;
            mask      <= mask_n;
            errmask   <= errmask_n;
            idle      <= idle_n;
            if (complete_c) begin
                value <= slots_n;
            end
            valid     <= complete_c;
            frame_err <= complete_c && err_any_c;
            timeout   <= expire_c;
        end
    end

endmodule

// File: tb/tb_seven_seg_reader.sv
// Bench for seven_seg_reader: directed scenarios plus random bus traffic against a
// run-length based reference model of the reader.
module tb_seven_seg_reader;

    localparam int unsigned S = 4;
    localparam int unsigned T = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  seg_in;
    logic [3:0]  dig_sel;
    logic [15:0] value;
    logic        valid;
    logic        frame_err;
    logic        timeout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int stray_err = 0;

    logic [6:0] enc [15];

    // Reference model state
    logic [10:0] m_s1, m_s2;
    int          run;
    logic [3:0]  m_slot [4];
    logic [3:0]  m_mask, m_err;
    int          m_idle;

    logic [16:0] exp_q[$], obs_q[$];
    int          exp_val_cyc[$], obs_val_cyc[$];
    int          exp_tmo_cyc[$], obs_tmo_cyc[$];

    seven_seg_reader #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk),
        .reset(reset),
        .seg_in(seg_in),
        .dig_sel(dig_sel),
        .value(value),
        .valid(valid),
        .frame_err(frame_err),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
        $fatal(1);
    end

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        ref_decode = 5'h10;
        for (int i = 0; i < 15; i++)
            if (enc[i] == p) ref_decode = {1'b0, 4'(i)};
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; run = 1000;
        m_mask = '0; m_err = '0; m_idle = 0;
        for (int k = 0; k < 4; k++) m_slot[k] = '0;
    endtask

    // One clock of the model: a digit is taken once the synchronised bus has shown the
    // same value for S+1 cycles in a row after a change.
    task automatic model_step(input logic [10:0] pins);
        logic [3:0] d;
        logic [4:0] r;
        d = m_s2[3:0];
        if (run == int'(S) + 1 && $countones(d) == 1) begin
            r = ref_decode(m_s2[10:4]);
            for (int k = 0; k < 4; k++)
                if (d[k]) begin
                    m_slot[k] = r[3:0];
                    m_mask[k] = 1'b1;
                    m_err[k]  = r[4];
                end
            m_idle = 0;
            if (m_mask == 4'hF) begin
                exp_q.push_back({|m_err, m_slot[3], m_slot[2], m_slot[1], m_slot[0]});
                exp_val_cyc.push_back(cyc);
                m_mask = '0;
                m_err  = '0;
            end
        end else begin
            m_idle++;
            if (m_mask != 0 && m_idle == int'(T) - 1) begin
                exp_tmo_cyc.push_back(cyc);
                m_mask = '0;
                m_err  = '0;
                m_idle = 0;
            end
        end
        if (m_s1 != m_s2) run = 1; else run++;
        m_s2 = m_s1;
        m_s1 = pins;
    endtask

    task automatic drive_cycle(input logic [6:0] s, input logic [3:0] d);
        @(negedge clk);
        seg_in  = s;
        dig_sel = d;
        @(posedge clk);
        cyc++;
        model_step({s, d});
        #1;
        if (valid) begin
            obs_q.push_back({frame_err, value});
            obs_val_cyc.push_back(cyc);
        end
        if (timeout) obs_tmo_cyc.push_back(cyc);
        if (frame_err && !valid) stray_err++;
    endtask

    task automatic hold(input logic [6:0] s, input logic [3:0] d, input int n);
        repeat (n) drive_cycle(s, d);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset   = 1'b1;
        seg_in  = '0;
        dig_sel = '0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        cyc++;
        model_step(11'h0);
        #1;
    endtask

    task automatic begin_test();
        exp_q.delete(); obs_q.delete();
        exp_val_cyc.delete(); obs_val_cyc.delete();
        exp_tmo_cyc.delete(); obs_tmo_cyc.delete();
        stray_err = 0;
    endtask

    task automatic test_reset();
        begin_test();
        apply_reset();
        total++; if (value !== 16'h0000) begin bad++; $display("FAIL reset_value got=%h want=0000", value); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", timeout); end
    endtask

    task automatic test_reset_mid();
        logic [16:0] got;
        begin_test();
        apply_reset();
        hold(enc[5], 4'b1000, 10);
        hold(enc[6], 4'b0100, 10);
        apply_reset();
        hold(enc[1], 4'b1000, 10);
        hold(enc[2], 4'b0100, 10);
        hold(enc[3], 4'b0010, 10);
        hold(enc[4], 4'b0001, 10);
        hold(7'h0, 4'h0, 5);
        got = (obs_q.size() > 0) ? obs_q[0] : 17'bx;
        total++; if (obs_q.size() != 1) begin bad++; $display("FAIL reset_mid_count got=%0d want=1", obs_q.size()); end
        total++; if (got !== {1'b0, 16'h1234}) begin bad++; $display("FAIL reset_mid_value got=%h want=01234", got); end
    endtask

    task automatic test_scan();
        logic [16:0] got;
        int lastp, vc;
        begin_test();
        apply_reset();
        hold(7'h0, 4'h0, 3);
        hold(enc[10], 4'b1000, 10);
        hold(enc[11], 4'b0100, 10);
        hold(enc[12], 4'b0010, 10);
        lastp = cyc;
        hold(enc[13], 4'b0001, 10);
        hold(7'h0, 4'h0, 5);
        got = (obs_q.size() > 0) ? obs_q[0] : 17'bx;
        vc  = (obs_val_cyc.size() > 0) ? obs_val_cyc[0] : -1;
        total++; if (obs_q.size() != 1) begin bad++; $display("FAIL scan_valid_cycles got=%0d want=1", obs_q.size()); end
        total++; if (got !== {1'b0, 16'hABCD}) begin bad++; $display("FAIL scan_value got=%h want=0abcd", got); end
        total++; if (vc != lastp + 2 + int'(S) + 1) begin bad++; $display("FAIL scan_latency got=%0d want=%0d", vc - lastp, 2 + S + 1); end
    endtask

    task automatic test_glitch();
        logic [16:0] got;
        begin_test();
        apply_reset();
        hold(enc[9], 4'b1000, 10);
        hold(enc[9], 4'b0100, 10);
        hold(enc[9], 4'b0010, 10);
        hold(enc[3], 4'b0001, 3);
        hold(enc[7], 4'b0001, 10);
        hold(7'h0, 4'h0, 5);
        got = (obs_q.size() > 0) ? obs_q[0] : 17'bx;
        total++; if (obs_q.size() != 1) begin bad++; $display("FAIL glitch_count got=%0d want=1", obs_q.size()); end
        total++; if (got !== {1'b0, 16'h9997}) begin bad++; $display("FAIL glitch_value got=%h want=09997", got); end
    endtask

    task automatic test_decode();
        logic [16:0] g0, g1;
        begin_test();
        apply_reset();
        hold(7'b0000000, 4'b1000, 10);
        hold(enc[0],     4'b0100, 10);
        hold(7'b0000000, 4'b0010, 10);
        hold(enc[1],     4'b0001, 10);
        hold(enc[8],     4'b1000, 10);
        hold(7'b1010101, 4'b0100, 10);
        hold(enc[8],     4'b0010, 10);
        hold(enc[8],     4'b0001, 10);
        hold(7'h0, 4'h0, 5);
        g0 = (obs_q.size() > 0) ? obs_q[0] : 17'bx;
        g1 = (obs_q.size() > 1) ? obs_q[1] : 17'bx;
        total++; if (obs_q.size() != 2) begin bad++; $display("FAIL decode_count got=%0d want=2", obs_q.size()); end
        total++; if (g0 !== {1'b0, 16'hE0E1}) begin bad++; $display("FAIL decode_e_value got=%h want=0e0e1", g0); end
        total++; if (g1 !== {1'b1, 16'h8088}) begin bad++; $display("FAIL decode_err_value got=%h want=18088", g1); end
    endtask

    task automatic test_digsel();
        begin_test();
        apply_reset();
        hold(enc[5], 4'b0011, 20);
        hold(enc[5], 4'b0000, 20);
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL digsel_valid got=%0d want=0", obs_q.size()); end
        total++; if (obs_tmo_cyc.size() != 0) begin bad++; $display("FAIL digsel_timeout got=%0d want=0", obs_tmo_cyc.size()); end
        total++; if (stray_err != 0) begin bad++; $display("FAIL digsel_err got=%0d want=0", stray_err); end
    endtask

    task automatic test_timeout();
        logic [16:0] got;
        int p, tc;
        begin_test();
        apply_reset();
        hold(enc[1], 4'b1000, 10);
        p = cyc;
        hold(enc[2], 4'b0100, 10);
        hold(7'h0, 4'h0, 45);
        tc = (obs_tmo_cyc.size() > 0) ? obs_tmo_cyc[0] : -1;
        total++; if (obs_tmo_cyc.size() != 1) begin bad++; $display("FAIL timeout_count got=%0d want=1", obs_tmo_cyc.size()); end
        total++; if (tc != p + 2 + int'(S) + int'(T)) begin bad++; $display("FAIL timeout_cycle got=%0d want=%0d", tc - p, 2 + S + T); end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL timeout_no_valid got=%0d want=0", obs_q.size()); end
        hold(enc[5], 4'b1000, 10);
        hold(enc[6], 4'b0100, 10);
        hold(enc[7], 4'b0010, 10);
        hold(enc[9], 4'b0001, 10);
        hold(7'h0, 4'h0, 5);
        got = (obs_q.size() > 0) ? obs_q[0] : 17'bx;
        total++; if (got !== {1'b0, 16'h5679}) begin bad++; $display("FAIL timeout_next_value got=%h want=05679", got); end
    endtask

    task automatic test_random();
        logic [6:0] s;
        logic [3:0] d;
        int n, r;
        begin_test();
        apply_reset();
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      d = 4'(1 << $urandom_range(0, 3));
            else if (r < 8) d = 4'h0;
            else            d = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) < 8) s = enc[$urandom_range(0, 14)];
            else                          s = 7'($urandom);
            n = $urandom_range(1, 14);
            if ($urandom_range(0, 29) == 0) n = 40;
            hold(s, d, n);
        end
        hold(7'h0, 4'h0, 40);
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_frames got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        total++; if (obs_tmo_cyc.size() != exp_tmo_cyc.size()) begin bad++; $display("FAIL rand_timeouts got=%0d want=%0d", obs_tmo_cyc.size(), exp_tmo_cyc.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_value[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]); end
            total++; if (obs_val_cyc[i] != exp_val_cyc[i]) begin bad++; $display("FAIL rand_valid_cycle[%0d] got=%0d want=%0d", i, obs_val_cyc[i], exp_val_cyc[i]); end
        end
        for (int i = 0; i < exp_tmo_cyc.size() && i < obs_tmo_cyc.size(); i++) begin
            total++; if (obs_tmo_cyc[i] != exp_tmo_cyc[i]) begin bad++; $display("FAIL rand_timeout_cycle[%0d] got=%0d want=%0d", i, obs_tmo_cyc[i], exp_tmo_cyc[i]); end
        end
        total++; if (stray_err != 0) begin bad++; $display("FAIL rand_stray_err got=%0d want=0", stray_err); end
    endtask

    initial begin
        enc = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011,
                7'b1110111, 7'b0011111, 7'b1111000, 7'b1100111, 7'b0000000};
        reset   = 1'b0;
        seg_in  = '0;
        dig_sel = '0;
        test_reset();
        test_reset_mid();
        test_scan();
        test_glitch();
        test_decode();
        test_digsel();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seven_seg_reader.md
Name: seven_seg_reader

Overview:
- Reverse direction of the team's hex-to-7-segment encoder. Samples an externally driven, time-multiplexed 4-digit 7-segment display bus (segments plus digit selects).
- Filters glitches and ghosting, decodes each stable segment pattern back to a 4-bit nibble, and assembles a 16-bit word with a per-frame valid pulse.
- Used to read display-bus peripherals and to loop back our own display driver in self-test.

Parameters:
STABLE_CYCLES, 4, consecutive identical synchronised samples required before a digit is captured (range 2..255)
TIMEOUT_CYCLES, 65535, idle cycles with no capture after which a partial frame is discarded (range 16..2^20-1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
seg_in  input  7  segment lines, active high, bit6=a .. bit0=g
dig_sel  input  4  digit select, active high, one-hot; bit3 = most significant digit
value  output  16  last completed frame, digit3 in [15:12] .. digit0 in [3:0]
valid  output  1  one-cycle pulse when value updates
frame_err  output  1  qualified by valid: some digit in the frame had an undecodable pattern
timeout  output  1  one-cycle pulse when a partial frame is discarded

Behaviour:
- Reset (async, active high): value=16'h0000, valid=0, frame_err=0, timeout=0. Sync flops, stability counter, capture mask, error mask, idle counter and armed flag are cleared. Reset mid-frame discards all partial data.
- Input synchronisation: seg_in and dig_sel each pass through 2 flops (s1 then s2). All later logic uses s2 and a registered copy of it, prev.
- Stability counter stab (8 bit):
  - If s2 != prev (any of the 11 bits), stab=0 and armed=1.
  - Otherwise stab increments, saturating at 255.
- Capture condition: stab==STABLE_CYCLES-1, armed=1, and s2 dig_sel is exactly one-hot. On capture, armed=0, so there is only one capture per stable period.
- dig_sel of 0 or multi-hot: no capture and no error.
- Decode table (exact inverse of the team encoder):
  - 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1110011->9, 1110111->A, 0011111->B, 1111000->C, 1100111->D, 0000000->E.
  - 1111111 always decodes to 8; F is not distinguishable.
  - Any other pattern: nibble=0 and the digit's error bit is set.
- Capture into digit k: nibble stored in slot k, mask[k]=1, errmask[k] set to the decode error. A repeat capture of the same digit before the frame completes overwrites the slot, its error bit, and its mask bit.
- Frame completion: in the cycle after the capture that makes mask==4'b1111:
  - value=slots, valid=1, frame_err=|errmask.
  - Mask and errmask are cleared in the same cycle.
  - value holds until the next completion.
- Latency: input change at the pins to the capture register is 2 (sync) + STABLE_CYCLES cycles. Capture to valid is 1 cycle.
- Idle counter: cleared on every capture, otherwise increments.
  - If it reaches TIMEOUT_CYCLES-1 with mask!=0: mask and errmask are cleared, timeout pulses for 1 cycle, and the counter clears.
  - With mask==0 the counter saturates silently.
- Simultaneous events: a timeout and a capture in the same cycle are resolved in favour of the capture (the timeout is not raised). valid and timeout are never high together.
- Static bus (never changes): at most one capture, so no frame ever completes. This is intended.

Test Plan:
- Reset mid-operation: apply reset after 2 captures of a frame, then scan 1,2,3,4 -> valid once with value=16'h1234 and frame_err=0; no stale nibbles.
- Scan digits 3..0 with patterns for A, B, C, D, each held 10 cycles (STABLE_CYCLES=4) -> value=16'hABCD, valid high exactly 1 cycle, first capture 6 cycles after the first pin change.
- Glitch rejection: hold digit0 pattern 3 cycles, change it, then hold 10 cycles -> only the second pattern is captured.
- Pattern 0000000 decodes to E; pattern 1010101 on digit2 with digits 3/1/0 = 8/8/8 -> value=16'h8088, frame_err=1.
- dig_sel=4'b0011 held 20 cycles, then 4'b0000 held 20 cycles -> no capture, no valid, no error.
- TIMEOUT_CYCLES=32: capture 2 digits then idle -> timeout pulses once, 32 cycles after the last capture. A subsequent full scan of 5,6,7,9 -> value=16'h5679.
